// File: rtl/execute_mdu.sv
// Execute-stage multiply/divide unit: owns HI/LO, runs mult/div with a fixed
// busy latency, and services mthi/mtlo/mfhi/mflo.
module execute_mdu #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [3:0]  mdu_op,
    input  logic [31:0] rs_data,
    input  logic [31:0] rt_data,
    output logic        busy,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic [31:0] mf_data
);

    localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CW         = $clog2(MAX_CYCLES + 1);
    localparam logic [CW-1:0] MULT_CNT = CW'(MULT_CYCLES);
    localparam logic [CW-1:0] DIV_CNT  = CW'(DIV_CYCLES);
    localparam logic [CW-1:0] CNT_ZERO = {CW{1'b0}};
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);

    typedef enum logic [3:0] {
        OP_NONE  = 4'd0,
        OP_MULT  = 4'd1,
        OP_MULTU = 4'd2,
        OP_DIV   = 4'd3,
        OP_DIVU  = 4'd4,
        OP_MTHI  = 4'd5,
        OP_MTLO  = 4'd6,
        OP_MFHI  = 4'd7,
        OP_MFLO  = 4'd8
    } mdu_op_e;

    // Magnitude of a value when treated as signed; 0x80000000 maps to itself as unsigned.
    function automatic logic [31:0] mag32(input logic [31:0] v, input logic is_signed);
        mag32 = (is_signed && v[31]) ? (32'd0 - v) : v;
    endfunction

    // Divide returning {remainder, quotient}; signed results derived from magnitudes so
    // 0x80000000 / -1 wraps to 0x80000000 without overflow. Zero divisor is handled by caller.
    function automatic logic [63:0] divide(input logic [31:0] a, input logic [31:0] b,
                                           input logic is_signed);
        logic [31:0] am, bm, q, r;
        am = mag32(a, is_signed);
        bm = mag32(b, is_signed);
        if (bm == 32'd0) begin
            bm = 32'd1;
        end else begin
            bm = bm;
        end
        q = am / bm;
        r = am % bm;
        if (is_signed && (a[31] ^ b[31])) begin
            q = 32'd0 - q;
        end else begin
            q = q;
        end
        if (is_signed && a[31]) begin
            r = 32'd0 - r;
        end else begin
            r = r;
        end
        divide = {r, q};
    endfunction

    mdu_op_e       op_s;
    logic          accept_s;
    logic [63:0]   prod_s;
    logic [63:0]   quot_rem_s;
    logic          is_signed_s;

    logic [CW-1:0] cnt_r,  cnt_s;
    logic [31:0]   ph_r,   ph_s;
    logic [31:0]   pl_r,   pl_s;
    logic          dz_r,   dz_s;
    logic [31:0]   hi_r,   hi_s;
    logic [31:0]   lo_r,   lo_s;
    logic          busy_r, busy_s;

    assign op_s     = mdu_op_e'(mdu_op);
    assign accept_s = start && (cnt_r == CNT_ZERO);

    // Operand arithmetic: sign-extend for signed ops so one 64-bit multiply covers both.
    always_comb begin
        is_signed_s = (op_s == OP_MULT) || (op_s == OP_DIV);
        prod_s      = {{32{is_signed_s & rs_data[31]}}, rs_data}
                    * {{32{is_signed_s & rt_data[31]}}, rt_data};
        quot_rem_s  = divide(rs_data, rt_data, is_signed_s);
    end

    // Next-state: count down an in-flight op and commit on 1->0, else accept a new op.
    always_comb begin
        cnt_s = cnt_r;
        ph_s  = ph_r;
        pl_s  = pl_r;
        dz_s  = dz_r;
        hi_s  = hi_r;
        lo_s  = lo_r;
        if (cnt_r != CNT_ZERO) begin
            cnt_s = cnt_r - CNT_ONE;
            if ((cnt_r == CNT_ONE) && !dz_r) begin
                hi_s = ph_r;
                lo_s = pl_r;
            end else begin
                hi_s = hi_r;
            end
        end else if (accept_s) begin
            case (op_s)
                OP_MULT, OP_MULTU: begin
                    {ph_s, pl_s} = prod_s;
                    dz_s         = 1'b0;
                    cnt_s        = MULT_CNT;
                end
                OP_DIV, OP_DIVU: begin
                    {ph_s, pl_s} = quot_rem_s;
                    dz_s         = (rt_data == 32'd0);
                    cnt_s        = DIV_CNT;
                end
                OP_MTHI: hi_s = rs_data;
                OP_MTLO: lo_s = rs_data;
                default: cnt_s = cnt_r;
            endcase
        end else begin
            cnt_s = cnt_r;
        end
        busy_s = (cnt_s != CNT_ZERO);
    end

    // State registers with synchronous reset; reset discards any in-flight result.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_r  <= CNT_ZERO;
            ph_r   <= 32'd0;
            pl_r   <= 32'd0;
            dz_r   <= 1'b0;
            hi_r   <= 32'd0;
            lo_r   <= 32'd0;
            busy_r <= 1'b0;
        end else begin
            cnt_r  <= cnt_s;
            ph_r   <= ph_s;
            pl_r   <= pl_s;
            dz_r   <= dz_s;
            hi_r   <= hi_s;
            lo_r   <= lo_s;
            busy_r <= busy_s;
        end
    end

    // Move-from read port; combinational so the E->M register can latch it directly.
    always_comb begin
        case (op_s)
            OP_MFHI: mf_data = hi_r;
            OP_MFLO: mf_data = lo_r;
            default: mf_data = 32'd0;
        endcase
    end

    assign busy = busy_r;
    assign hi   = hi_r;
    assign lo   = lo_r;

endmodule

// File: tb/tb_execute_mdu.sv
// Scoreboard bench for execute_mdu: stimulus pushes expected commits, a monitor
// pops them when busy falls; a plain-arithmetic model tracks HI/LO.
module tb_execute_mdu;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [3:0]  mdu_op;
    logic [31:0] rs_data;
    logic [31:0] rt_data;
    logic        busy;
    logic [31:0] hi;
    logic [31:0] lo;
    logic [31:0] mf_data;

    execute_mdu #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
        .clk     (clk),
        .reset   (reset),
        .start   (start),
        .mdu_op  (mdu_op),
        .rs_data (rs_data),
        .rt_data (rt_data),
        .busy    (busy),
        .hi      (hi),
        .lo      (lo),
        .mf_data (mf_data)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        int          len;
    } exp_t;

    exp_t        sb_q[$];
    int          total = 0;
    int          bad   = 0;
    logic [31:0] model_hi = 32'd0;
    logic [31:0] model_lo = 32'd0;
    logic [31:0] pend_hi;
    logic [31:0] pend_lo;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference: {hi, lo} from plain 64-bit arithmetic.
    function automatic logic [63:0] ref_result(input logic [3:0] op, input logic [31:0] a,
                                               input logic [31:0] b);
        longint      sa, sb, q, r;
        logic [63:0] ua, ub, p;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = {32'd0, a};
        ub = {32'd0, b};
        case (op)
            4'd1: p = sa * sb;
            4'd2: p = ua * ub;
            4'd3: begin q = sa / sb; r = sa % sb; p = {r[31:0], q[31:0]}; end
            4'd4: p = {32'(a % b), 32'(a / b)};
            default: p = 64'd0;
        endcase
        return p;
    endfunction

    // Drive one op at a negedge; leaves at the following negedge with start low.
    task automatic launch(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        exp_t        e;
        logic [63:0] r;
        start = 1'b1; mdu_op = op; rs_data = a; rt_data = b;
        if (op >= 4'd1 && op <= 4'd4) begin
            if (op >= 4'd3 && b == 32'd0) r = {model_hi, model_lo};
            else                          r = ref_result(op, a, b);
            e.hi = r[63:32]; e.lo = r[31:0];
            e.len = (op <= 4'd2) ? 5 : 10;
            sb_q.push_back(e);
            pend_hi = e.hi; pend_lo = e.lo;
        end
        @(negedge clk);
        start = 1'b0; mdu_op = 4'd0;
        if (op == 4'd5) model_hi = a;
        if (op == 4'd6) model_lo = a;
    endtask

    task automatic finish_op();
        int n = 0;
        while (busy === 1'b1 && n < 40) begin
            @(negedge clk);
            n++;
        end
        if (n >= 40) check("busy_timeout", 32'(busy), 32'd0);
        model_hi = pend_hi;
        model_lo = pend_lo;
    endtask

    task automatic do_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        launch(op, a, b);
        if (op >= 4'd1 && op <= 4'd4) finish_op();
    endtask

    task automatic check_state(input string tag);
        check({tag, "_hi"}, hi, model_hi);
        check({tag, "_lo"}, lo, model_lo);
        check({tag, "_busy"}, 32'(busy), 32'd0);
        mdu_op = 4'd7; #1 check({tag, "_mfhi"}, mf_data, model_hi);
        mdu_op = 4'd8; #1 check({tag, "_mflo"}, mf_data, model_lo);
        mdu_op = 4'd0; #1 check({tag, "_mfnone"}, mf_data, 32'd0);
        @(negedge clk);
    endtask

    // Monitor: counts busy cycles and checks the commit when busy falls.
    initial begin
        int   run;
        logic prev;
        exp_t e;
        run = 0; prev = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (reset) begin
                run = 0; prev = 1'b0;
            end else if (busy) begin
                run++; prev = 1'b1;
            end else begin
                if (prev) begin
                    if (sb_q.size() == 0) begin
                        check("unexpected_commit", 32'd1, 32'd0);
                    end else begin
                        e = sb_q.pop_front();
                        check("commit_hi", hi, e.hi);
                        check("commit_lo", lo, e.lo);
                        check("busy_len", 32'(run), 32'(e.len));
                    end
                end
                prev = 1'b0; run = 0;
            end
        end
    end

    initial begin
        logic [3:0]  op;
        logic [31:0] a, b;
        reset = 1'b1; start = 1'b0; mdu_op = 4'd0; rs_data = 32'd0; rt_data = 32'd0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        check_state("reset");

        // Reset in the third busy cycle of a MULT discards it.
        launch(4'd1, 32'h0001_2345, 32'h0006_7890);
        @(negedge clk);
        reset = 1'b1;
        sb_q.delete();
        @(negedge clk);
        reset = 1'b0;
        check("rst_mid_busy", 32'(busy), 32'd0);
        check("rst_mid_hi", hi, 32'd0);
        check("rst_mid_lo", lo, 32'd0);
        repeat (3) @(negedge clk);
        check("rst_nocommit_hi", hi, 32'd0);
        check("rst_nocommit_lo", lo, 32'd0);
        check("rst_nocommit_busy", 32'(busy), 32'd0);

        do_op(4'd1, 32'hFFFF_FFFF, 32'd2);
        check("mult_hi", hi, 32'hFFFF_FFFF);
        check("mult_lo", lo, 32'hFFFF_FFFE);
        do_op(4'd2, 32'hFFFF_FFFF, 32'd2);
        check("multu_hi", hi, 32'd1);
        check("multu_lo", lo, 32'hFFFF_FFFE);
        do_op(4'd3, 32'hFFFF_FFF9, 32'd2);
        check("div_lo", lo, 32'hFFFF_FFFD);
        check("div_hi", hi, 32'hFFFF_FFFF);
        do_op(4'd4, 32'd7, 32'd2);
        check("divu_lo", lo, 32'd3);
        check("divu_hi", hi, 32'd1);

        do_op(4'd5, 32'h1234_5678, 32'd0);
        check("mthi_busy", 32'(busy), 32'd0);
        do_op(4'd6, 32'h9ABC_DEF0, 32'd0);
        check("mtlo_hi", hi, 32'h1234_5678);
        check_state("mt");

        do_op(4'd5, 32'h0000_AAAA, 32'd0);
        do_op(4'd6, 32'h0000_5555, 32'd0);
        do_op(4'd3, 32'd1234, 32'd0);
        check("div0_hi", hi, 32'h0000_AAAA);
        check("div0_lo", lo, 32'h0000_5555);
        do_op(4'd3, 32'h8000_0000, 32'hFFFF_FFFF);
        check("divovf_lo", lo, 32'h8000_0000);
        check("divovf_hi", hi, 32'd0);

        // Start while busy is ignored; mfhi during busy reads the old HI.
        launch(4'd1, 32'd1000, 32'd3000);
        @(negedge clk);
        start = 1'b1; mdu_op = 4'd1; rs_data = 32'h7777_7777; rt_data = 32'h3333_3333;
        @(negedge clk);
        start = 1'b0; mdu_op = 4'd7;
        #1 check("mfhi_busy", mf_data, model_hi);
        mdu_op = 4'd0;
        @(negedge clk);
        finish_op();
        check("inject_lo", lo, 32'd3000000);
        launch(4'd1, 32'hFFFF_FFFD, 32'd7);
        check("b2b_busy", 32'(busy), 32'd1);
        finish_op();
        check_state("b2b");

        for (int i = 0; i < 30; i++) begin
            op = 4'($urandom_range(1, 7));
            if (op == 4'd7) op = 4'($urandom_range(7, 15));
            a = $urandom;
            b = ($urandom_range(0, 3) == 0) ? 32'd0 : $urandom;
            if ($urandom_range(0, 5) == 0) begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
            if ((op == 4'd1 || op == 4'd2) && b == 32'd0) b = $urandom;
            do_op(op, a, b);
            check_state("rand");
        end

        check("queue_empty", 32'(sb_q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
